rsa_word_bridge: RTL and testbench

- Host-side counterpart of the RSA core: the initiator that drives the core's RSAModIn valid/ready input and consumes its RSAModOut valid/ready output.
- Deserializes a narrow word stream into msg, key and modulus and issues one request to the core.
- Waits for the crypto result, then serializes it back out as a word stream with a last-word marker.
- Sits between a host bus adapter and the RSA top.

---
 rtl/rsa_word_bridge.sv | 116 +++++++++++
 tb/tb_rsa_word_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_word_bridge.sv
// Host-side word bridge for the RSA core: gathers msg/key/modulus from a word
// stream, issues one core request, then streams the result back out LSW first.
module rsa_word_bridge #(
    parameter int MOD_WIDTH  = 256,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    output logic                  core_valid,
    input  logic                  core_ready,
    output logic [MOD_WIDTH-1:0]  core_msg,
    output logic [MOD_WIDTH-1:0]  core_key,
    output logic [MOD_WIDTH-1:0]  core_modulus,
    input  logic                  core_o_valid,
    output logic                  core_o_ready,
    input  logic [MOD_WIDTH-1:0]  core_crypto,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int NW = MOD_WIDTH / WORD_WIDTH;
    localparam int CW = $clog2(3 * NW);
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(3 * NW - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, SEND} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [3*MOD_WIDTH-1:0]   operands;
    logic [MOD_WIDTH-1:0]     result;
    logic [CW-1:0]            cnt;
    logic [IW-1:0]            idx;

    // Words enter at the top of a shift register, so after 3*NW accepts the
    // first word sits at bit 0: msg low third, key middle, modulus top.
    assign core_msg     = operands[MOD_WIDTH-1:0];
    assign core_key     = operands[2*MOD_WIDTH-1:MOD_WIDTH];
    assign core_modulus = operands[3*MOD_WIDTH-1:2*MOD_WIDTH];
    assign m_data       = result[WORD_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        s_ready      = 1'b0;
        core_valid   = 1'b0;
        core_o_ready = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        case (state)
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid && cnt == LAST_CNT) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                core_valid = 1'b1;
                if (core_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                core_o_ready = 1'b1;
                if (core_o_valid) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                m_last  = (idx == LAST_IDX);
                if (m_ready && idx == LAST_IDX) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // The result shifts down one word per output handshake and fills with
    // zeros, so m_data returns to 0 once the frame has been fully sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            operands <= '0;
            result   <= '0;
            cnt      <= '0;
            idx      <= '0;
        end else begin
            if (s_valid && s_ready) begin
                operands <= {s_data, operands[3*MOD_WIDTH-1:WORD_WIDTH]};
                cnt      <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
            end
            if (core_o_valid && core_o_ready) begin
                result <= core_crypto;
            end
            if (m_valid && m_ready) begin
                result <= result >> WORD_WIDTH;
                idx    <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rsa_word_bridge.sv
// Self-checking bench for rsa_word_bridge: the bench plays host, RSA core and
// sink, and checks every cycle against frame-level expectations.
module tb_rsa_word_bridge;

    localparam int MW = 256;
    localparam int WW = 32;
    localparam int NW = MW / WW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [WW-1:0] s_data;
    logic          core_valid;
    logic          core_ready;
    logic [MW-1:0] core_msg;
    logic [MW-1:0] core_key;
    logic [MW-1:0] core_modulus;
    logic          core_o_valid;
    logic          core_o_ready;
    logic [MW-1:0] core_crypto;
    logic          m_valid;
    logic          m_ready;
    logic [WW-1:0] m_data;
    logic          m_last;

    int checks = 0;
    int failures = 0;
    int cycleNo = 0;
    int lastOutEdge = -100;

    logic [WW-1:0] frameWords [3*NW];
    logic [MW-1:0] expResult;

    rsa_word_bridge #(.MOD_WIDTH(MW), .WORD_WIDTH(WW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_valid(core_valid), .core_ready(core_ready),
        .core_msg(core_msg), .core_key(core_key), .core_modulus(core_modulus),
        .core_o_valid(core_o_valid), .core_o_ready(core_o_ready), .core_crypto(core_crypto),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycleNo);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    function automatic logic [MW-1:0] randWide();
        logic [MW-1:0] v;
        for (int i = 0; i < NW; i++) v[i*WW +: WW] = $urandom();
        return v;
    endfunction

    // Field f of the frame as a number: word i contributes word * 2^(WW*i).
    function automatic logic [MW-1:0] field(input int f);
        logic [MW-1:0] v;
        v = '0;
        for (int i = 0; i < NW; i++) v = v | (MW'(frameWords[f*NW+i]) << (WW * i));
        return v;
    endfunction

    task automatic setRandomFrame();
        for (int i = 0; i < 3*NW; i++) frameWords[i] = $urandom();
        expResult = randWide();
    endtask

    task automatic setDirectedFrame(input logic [WW-1:0] msgFirst);
        for (int i = 0; i < NW; i++) begin
            frameWords[i]        = msgFirst + WW'(i);
            frameWords[NW+i]     = WW'(32'h101 + i);
            frameWords[2*NW+i]   = WW'(32'h201 + i);
            expResult[i*WW +: WW] = WW'(32'hA0 + i);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_s_ready"}, MW'(s_ready), MW'(1));
        checkOutput({tag, "_core_valid"}, MW'(core_valid), MW'(0));
        checkOutput({tag, "_core_o_ready"}, MW'(core_o_ready), MW'(0));
        checkOutput({tag, "_m_valid"}, MW'(m_valid), MW'(0));
        checkOutput({tag, "_m_last"}, MW'(m_last), MW'(0));
        checkOutput({tag, "_m_data"}, MW'(m_data), MW'(0));
        checkOutput({tag, "_core_msg"}, core_msg, '0);
        checkOutput({tag, "_core_key"}, core_key, '0);
        checkOutput({tag, "_core_modulus"}, core_modulus, '0);
    endtask

    // One full frame: load 3*NW words, core handshake, result out NW words.
    task automatic applyStimulus(input int gapPct, input int readyStall, input int latency,
                                 input int mStallPct, input int word2Stall,
                                 input bit keepValid, input bit checkBackToBack);
        int  i;
        int  budget;
        int  idx;
        int  stallLeft;
        bit  firstAccept;
        i = 0;
        budget = 0;
        firstAccept = 1'b1;
        while (i < 3*NW && budget < 3*NW*30) begin
            s_valid      = (gapPct == 0) || ($urandom_range(99) >= gapPct);
            s_data       = s_valid ? frameWords[i] : WW'($urandom());
            core_o_valid = 1'($urandom_range(1));
            core_crypto  = randWide();
            checkOutput("load_s_ready", MW'(s_ready), MW'(1));
            checkOutput("load_core_o_ready", MW'(core_o_ready), MW'(0));
            checkOutput("load_core_valid", MW'(core_valid), MW'(0));
            if (s_valid && firstAccept && checkBackToBack) begin
                checkOutput("back_to_back_accept", MW'(cycleNo + 1 - lastOutEdge), MW'(1));
            end
            cycle();
            budget++;
            if (s_valid) begin
                i++;
                firstAccept = 1'b0;
            end
        end
        s_valid      = keepValid;
        s_data       = WW'($urandom());
        core_o_valid = 1'b0;
        if (i < 3*NW) begin
            checkOutput("load_timeout", MW'(i), MW'(3*NW));
            return;
        end

        checkOutput("issue_core_valid", MW'(core_valid), MW'(1));
        checkOutput("issue_s_ready", MW'(s_ready), MW'(0));
        checkOutput("issue_msg", core_msg, field(0));
        checkOutput("issue_key", core_key, field(1));
        checkOutput("issue_modulus", core_modulus, field(2));
        core_ready = 1'b0;
        repeat (readyStall) begin
            cycle();
            checkOutput("stall_core_valid", MW'(core_valid), MW'(1));
            checkOutput("stall_msg", core_msg, field(0));
            checkOutput("stall_key", core_key, field(1));
            checkOutput("stall_modulus", core_modulus, field(2));
        end
        core_ready = 1'b1;
        cycle();
        core_ready = 1'b0;
        checkOutput("issue_once", MW'(core_valid), MW'(0));

        for (int k = 0; k < latency; k++) begin
            checkOutput("wait_core_o_ready", MW'(core_o_ready), MW'(1));
            checkOutput("wait_m_valid", MW'(m_valid), MW'(0));
            cycle();
        end
        core_o_valid = 1'b1;
        core_crypto  = expResult;
        checkOutput("result_core_o_ready", MW'(core_o_ready), MW'(1));
        cycle();
        core_o_valid = 1'b0;
        core_crypto  = randWide();
        checkOutput("after_result_core_o_ready", MW'(core_o_ready), MW'(0));

        idx = 0;
        budget = 0;
        stallLeft = word2Stall;
        while (idx < NW && budget < NW*60) begin
            checkOutput("send_m_valid", MW'(m_valid), MW'(1));
            checkOutput("send_m_data", MW'(m_data), MW'(expResult[idx*WW +: WW]));
            checkOutput("send_m_last", MW'(m_last), MW'(idx == NW-1));
            checkOutput("send_s_ready", MW'(s_ready), MW'(0));
            if (idx == 2 && stallLeft > 0) begin
                m_ready = 1'b0;
                stallLeft--;
            end else begin
                m_ready = ($urandom_range(99) >= mStallPct);
            end
            cycle();
            budget++;
            if (m_ready) begin
                if (idx == NW-1) lastOutEdge = cycleNo;
                idx++;
            end
        end
        m_ready = 1'b0;
        if (idx < NW) begin
            checkOutput("send_timeout", MW'(idx), MW'(NW));
            return;
        end
        checkOutput("done_m_valid", MW'(m_valid), MW'(0));
        checkOutput("done_m_last", MW'(m_last), MW'(0));
        checkOutput("done_s_ready", MW'(s_ready), MW'(1));
    endtask

    initial begin
        rst          = 1'b1;
        s_valid      = 1'b0;
        s_data       = '0;
        core_ready   = 1'b0;
        core_o_valid = 1'b0;
        core_crypto  = '0;
        m_ready      = 1'b0;
        cycle();
        cycle();
        checkResetValues("reset");
        rst = 1'b0;

        // Directed frame with one word per cycle and a fully ready sink.
        setDirectedFrame(WW'(32'h1));
        applyStimulus(0, 0, 0, 0, 0, 1'b0, 1'b0);
        checkOutput("t1_msg_lsw", MW'(core_msg[31:0]), MW'(32'h1));
        checkOutput("t1_msg_msw", MW'(core_msg[255:224]), MW'(32'h8));
        checkOutput("t1_mod_msw", MW'(core_modulus[255:224]), MW'(32'h208));

        // Sink stall while word index 2 is presented.
        setDirectedFrame(WW'(32'h31));
        applyStimulus(0, 0, 1, 0, 5, 1'b0, 1'b0);

        // Core holds off the request for 10 cycles.
        setRandomFrame();
        applyStimulus(0, 10, 2, 0, 0, 1'b0, 1'b0);

        // Abort a partial frame with a one-cycle reset.
        setRandomFrame();
        s_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            s_data = frameWords[k];
            cycle();
        end
        s_valid = 1'b0;
        rst = 1'b1;
        cycle();
        checkResetValues("midreset");
        rst = 1'b0;
        setDirectedFrame(WW'(32'h11));
        applyStimulus(0, 0, 0, 0, 0, 1'b0, 1'b0);
        checkOutput("t5_msg_lsw", MW'(core_msg[31:0]), MW'(32'h11));

        // Continuous s_valid across two frames, 3-cycle core latency.
        setRandomFrame();
        applyStimulus(0, 0, 3, 0, 0, 1'b1, 1'b0);
        setRandomFrame();
        applyStimulus(0, 0, 3, 0, 0, 1'b0, 1'b1);

        // Randomized frames with gaps, stalls and varied latency.
        for (int f = 0; f < 8; f++) begin
            setRandomFrame();
            applyStimulus($urandom_range(50), $urandom_range(6), $urandom_range(5),
                          $urandom_range(50), 0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
